// File: rtl/imem_pkg.sv
// imem_pkg: constants shared by the instruction memory, its loader and the decoder
package imem_pkg;
  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;
  localparam logic [15:0] NOP_DEFAULT = 16'hF000;
  localparam int OPC_W = 4;
  localparam int REG_W = 3;
endpackage

// File: rtl/imem_loader.sv
// imem_loader: RUN/LOAD burst FSM, load pointer, overflow flag and write strobe
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_start,
  input  logic [ADDR_WIDTH-1:0] ld_base,
  input  logic                  ld_valid,
  input  logic                  ld_last,
  output logic                  busy,
  output logic                  start_acc,
  output logic                  ld_ovf,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] wr_addr
);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  logic [0:0] state;
  logic [ADDR_WIDTH:0] ptr;
  logic in_rng;
  assign busy = state == ST_LOAD;
  assign start_acc = !busy && ld_start;
  assign in_rng = ptr < DEPTH_W;
  assign we = busy && ld_valid && in_rng;
  assign wr_addr = ptr[ADDR_WIDTH-1:0];
  // the extra pointer bit keeps runaway bursts out of range instead of wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      ptr <= '0;
      ld_ovf <= 1'b0;
    end else if (start_acc) begin
      state <= ST_LOAD;
      ptr <= {1'b0, ld_base};
      ld_ovf <= 1'b0;
    end else if (busy && ld_valid) begin
      ptr <= &ptr ? ptr : ptr + 1'b1;
      if (!in_rng) ld_ovf <= 1'b1;
      if (ld_last) state <= ST_RUN;
    end
  end
endmodule

// File: rtl/inst_mem_sync.sv
// inst_mem_sync: IF-stage instruction memory with registered fetch and streaming program load
module inst_mem_sync
  import imem_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH = 256,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = NOP_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  fetch_err,
  input  logic                  ld_start,
  input  logic [ADDR_WIDTH-1:0] ld_base,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  busy,
  output logic                  ld_ovf
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic start_acc, we, in_rng;
  logic [ADDR_WIDTH-1:0] wr_addr;
  imem_loader #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_loader (
    .clk(clk),
    .reset(reset),
    .ld_start(ld_start),
    .ld_base(ld_base),
    .ld_valid(ld_valid),
    .ld_last(ld_last),
    .busy(busy),
    .start_acc(start_acc),
    .ld_ovf(ld_ovf),
    .we(we),
    .wr_addr(wr_addr)
  );
  assign in_rng = {1'b0, fetch_addr} < DEPTH_W;
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr[IW-1:0]] <= ld_data;
  end
  // entering or sitting in LOAD kills the output even under stall
  always_ff @(posedge clk) begin
    if (reset || busy || start_acc || flush) begin
      fetch_valid <= 1'b0;
      fetch_data <= NOP_WORD;
      fetch_err <= 1'b0;
    end else if (!stall) begin
      fetch_valid <= fetch_req;
      fetch_data <= fetch_req && in_rng ? mem[fetch_addr[IW-1:0]] : NOP_WORD;
      fetch_err <= fetch_req && !in_rng;
    end
  end
endmodule

// File: tb/tb_inst_mem_sync.sv
// tb_inst_mem_sync: directed vector and sequence checks for inst_mem_sync with DEPTH=10
module tb_inst_mem_sync;
  logic clk = 0, reset = 1, fetch_req = 0, stall = 0, flush = 0;
  logic ld_start = 0, ld_valid = 0, ld_last = 0;
  logic [7:0] fetch_addr = 0, ld_base = 0;
  logic [15:0] ld_data = 0;
  logic fetch_valid, fetch_err, busy, ld_ovf;
  logic [15:0] fetch_data;
  int total = 0, passed = 0;
  typedef struct {
    logic req;
    logic [7:0] addr;
    logic stall;
    logic flush;
    logic v;
    logic [15:0] d;
    logic e;
  } vec_t;
  vec_t vt[16];
  inst_mem_sync #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(10), .NOP_WORD(16'hF000)) dut (
    .clk(clk),
    .reset(reset),
    .fetch_req(fetch_req),
    .fetch_addr(fetch_addr),
    .stall(stall),
    .flush(flush),
    .fetch_valid(fetch_valid),
    .fetch_data(fetch_data),
    .fetch_err(fetch_err),
    .ld_start(ld_start),
    .ld_base(ld_base),
    .ld_valid(ld_valid),
    .ld_data(ld_data),
    .ld_last(ld_last),
    .busy(busy),
    .ld_ovf(ld_ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask
  task automatic chk_f(input string nm, input logic v, input logic [15:0] d, input logic e);
    chk(nm, {13'd0, fetch_valid, fetch_data, fetch_err}, {13'd0, v, d, e});
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic ld_word(input logic [15:0] d, input logic last);
    ld_valid = 1;
    ld_data = d;
    ld_last = last;
    tick();
    ld_valid = 0;
    ld_last = 0;
  endtask
  task automatic fetch(input logic [7:0] a);
    fetch_req = 1;
    fetch_addr = a;
    tick();
    fetch_req = 0;
  endtask
  initial begin
    vt[0]  = '{1'b1, 8'd0,   1'b0, 1'b0, 1'b1, 16'h0030, 1'b0};
    vt[1]  = '{1'b1, 8'd1,   1'b0, 1'b0, 1'b1, 16'hC241, 1'b0};
    vt[2]  = '{1'b1, 8'd0,   1'b1, 1'b0, 1'b1, 16'hC241, 1'b0};
    vt[3]  = '{1'b1, 8'd0,   1'b1, 1'b0, 1'b1, 16'hC241, 1'b0};
    vt[4]  = '{1'b1, 8'd0,   1'b1, 1'b0, 1'b1, 16'hC241, 1'b0};
    vt[5]  = '{1'b1, 8'd0,   1'b0, 1'b0, 1'b1, 16'h0030, 1'b0};
    vt[6]  = '{1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 16'hF000, 1'b0};
    vt[7]  = '{1'b1, 8'd1,   1'b0, 1'b0, 1'b1, 16'hC241, 1'b0};
    vt[8]  = '{1'b1, 8'd1,   1'b1, 1'b1, 1'b0, 16'hF000, 1'b0};
    vt[9]  = '{1'b0, 8'd1,   1'b1, 1'b0, 1'b0, 16'hF000, 1'b0};
    vt[10] = '{1'b1, 8'd12,  1'b0, 1'b0, 1'b1, 16'hF000, 1'b1};
    vt[11] = '{1'b1, 8'd0,   1'b1, 1'b0, 1'b1, 16'hF000, 1'b1};
    vt[12] = '{1'b1, 8'd10,  1'b0, 1'b0, 1'b1, 16'hF000, 1'b1};
    vt[13] = '{1'b1, 8'd255, 1'b0, 1'b0, 1'b1, 16'hF000, 1'b1};
    vt[14] = '{1'b1, 8'd0,   1'b0, 1'b1, 1'b0, 16'hF000, 1'b0};
    vt[15] = '{1'b1, 8'd0,   1'b0, 1'b0, 1'b1, 16'h0030, 1'b0};
    tick();
    reset = 0;
    chk_f("reset_fetch", 1'b0, 16'hF000, 1'b0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ovf", {31'd0, ld_ovf}, 32'd0);
    ld_start = 1;
    ld_base = 0;
    tick();
    ld_start = 0;
    chk("load_busy", {31'd0, busy}, 32'd1);
    ld_word(16'h0030, 1'b0);
    chk("load_busy_mid", {31'd0, busy}, 32'd1);
    ld_word(16'hC241, 1'b1);
    chk("load_busy_drop", {31'd0, busy}, 32'd0);
    chk("load_ovf_clear", {31'd0, ld_ovf}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      fetch_req = vt[i].req;
      fetch_addr = vt[i].addr;
      stall = vt[i].stall;
      flush = vt[i].flush;
      tick();
      chk_f($sformatf("vec%0d", i), vt[i].v, vt[i].d, vt[i].e);
    end
    stall = 0;
    flush = 0;
    fetch_req = 1;
    fetch_addr = 0;
    tick();
    chk_f("pre_load_fetch", 1'b1, 16'h0030, 1'b0);
    ld_start = 1;
    ld_base = 9;
    stall = 1;
    tick();
    ld_start = 0;
    stall = 0;
    chk_f("start_invalidates", 1'b0, 16'hF000, 1'b0);
    chk("ovf_load_busy", {31'd0, busy}, 32'd1);
    ld_last = 1;
    tick();
    ld_last = 0;
    chk("last_no_valid", {31'd0, busy}, 32'd1);
    chk_f("fetch_in_load", 1'b0, 16'hF000, 1'b0);
    ld_word(16'hAAAA, 1'b0);
    chk("ovf_first_ok", {31'd0, ld_ovf}, 32'd0);
    ld_word(16'hBBBB, 1'b0);
    chk("ovf_set", {31'd0, ld_ovf}, 32'd1);
    chk_f("fetch_in_load2", 1'b0, 16'hF000, 1'b0);
    ld_word(16'hCCCC, 1'b1);
    fetch_req = 0;
    chk("ovf_end_busy", {31'd0, busy}, 32'd0);
    chk("ovf_sticky", {31'd0, ld_ovf}, 32'd1);
    fetch(8'd9);
    chk_f("fetch_a9", 1'b1, 16'hAAAA, 1'b0);
    fetch(8'd0);
    chk_f("fetch_a0_intact", 1'b1, 16'h0030, 1'b0);
    ld_start = 1;
    ld_base = 2;
    tick();
    chk("restart_ovf_clr", {31'd0, ld_ovf}, 32'd0);
    ld_base = 7;
    ld_word(16'h1111, 1'b0);
    ld_start = 0;
    ld_word(16'h2222, 1'b0);
    reset = 1;
    tick();
    reset = 0;
    chk("midload_reset_busy", {31'd0, busy}, 32'd0);
    chk("midload_reset_ovf", {31'd0, ld_ovf}, 32'd0);
    fetch(8'd2);
    chk_f("fetch_a2", 1'b1, 16'h1111, 1'b0);
    fetch(8'd3);
    chk_f("fetch_a3", 1'b1, 16'h2222, 1'b0);
    fetch(8'd1);
    chk_f("reset_keeps_mem", 1'b1, 16'hC241, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
